// File: rtl/uart_rx_inport_pkg.sv
// Shared definitions for the UART receive input port: default port IDs,
// status word bit positions and the status word packing helper.
package uart_rx_inport_pkg;

    // Default PORT_ID assignments on the Tramelblaze input bus
    localparam logic [15:0] RX_PORT_ID   = 16'h0000;
    localparam logic [15:0] STAT_PORT_ID = 16'h0001;

    // Status word bit positions
    localparam int ST_NEMPTY  = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_FERR    = 3;
    localparam int ST_PERR    = 4;
    localparam int ST_CNT_LSB = 8;
    localparam int ST_CNT_W   = 8;

    // Sticky receive error flags, cleared together by a status read
    typedef struct packed {
        logic perr;
        logic ferr;
        logic ovf;
    } sticky_t;

    // Assemble the 16-bit status word; count arrives already zero-extended
    function automatic logic [15:0] pack_status(
        input logic [ST_CNT_W-1:0] cnt,
        input sticky_t             flags,
        input logic                full,
        input logic                nempty
    );
        logic [15:0] st;
        st                           = '0;
        st[ST_NEMPTY]                = nempty;
        st[ST_FULL]                  = full;
        st[ST_OVF]                   = flags.ovf;
        st[ST_FERR]                  = flags.ferr;
        st[ST_PERR]                  = flags.perr;
        st[ST_CNT_LSB +: ST_CNT_W]   = cnt;
        return st;
    endfunction

endpackage

// File: rtl/uart_rx_inport_byte_fifo.sv
// Byte FIFO for received UART characters. A push into a full FIFO is only
// accepted when a pop frees a slot in the same cycle; a pop on an empty FIFO
// is ignored. Storage is not reset, only pointers and occupancy.
module uart_rx_inport_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    wdata_i,
    input  logic          push_i,
    input  logic          pop_i,
    output logic [7:0]    rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output logic          push_acc_o
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          full, empty;
    logic          push_acc, pop_acc;

    // Accept/decline decisions and next pointer/occupancy values
    always_comb begin
        full     = (count_q == CNT_FULL);
        empty    = (count_q == '0);
        pop_acc  = pop_i & ~empty;
        push_acc = push_i & (~full | pop_acc);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write for accepted bytes
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o    = mem_q[rd_ptr_q];
    assign full_o     = full;
    assign empty_o    = empty;
    assign count_o    = count_q;
    assign push_acc_o = push_acc;

endmodule

// File: rtl/uart_rx_inport.sv
// Tramelblaze input-side UART port: queues received bytes, keeps sticky
// receive error flags, serves data/status on IN_PORT with one cycle of
// latency and raises a level interrupt cleared by INTERRUPT_ACK.
module uart_rx_inport #(
    parameter int          DEPTH        = 8,
    parameter int          AW           = 3,
    parameter logic [15:0] RX_PORT_ID   = uart_rx_inport_pkg::RX_PORT_ID,
    parameter logic [15:0] STAT_PORT_ID = uart_rx_inport_pkg::STAT_PORT_ID
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    input  logic        rx_ferr,
    input  logic        rx_perr,
    input  logic [15:0] port_id,
    input  logic        read_strobe,
    input  logic        interrupt_ack,
    output logic [15:0] in_port,
    output logic        interrupt
);

    import uart_rx_inport_pkg::*;

    logic [7:0]  fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    logic        push_acc;

    logic        sel_rx, sel_stat;
    logic        pop_req, clr_req, drop;

    sticky_t     flags_q, flags_d;
    logic        irq_q, irq_d;
    logic [15:0] in_port_q, in_port_d;

    uart_rx_inport_byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wdata_i    (rx_data),
        .push_i     (rx_rdy),
        .pop_i      (pop_req),
        .rdata_o    (fifo_rdata),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .push_acc_o (push_acc)
    );

    // Port decode, sticky flag and interrupt next-state; sets beat clears
    always_comb begin
        sel_rx   = (port_id == RX_PORT_ID);
        sel_stat = (port_id == STAT_PORT_ID);
        pop_req  = read_strobe & sel_rx;
        clr_req  = read_strobe & sel_stat;
        drop     = rx_rdy & ~push_acc;

        flags_d.ovf  = drop              | (flags_q.ovf  & ~clr_req);
        flags_d.ferr = (rx_rdy & rx_ferr) | (flags_q.ferr & ~clr_req);
        flags_d.perr = (rx_rdy & rx_perr) | (flags_q.perr & ~clr_req);

        if (push_acc) begin
            irq_d = 1'b1;
        end else if (interrupt_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Read mux: what IN_PORT will show next cycle for the current PORT_ID
    always_comb begin
        in_port_d = 16'h0000;
        if (sel_rx) begin
            if (!fifo_empty) begin
                in_port_d = {8'h00, fifo_rdata};
            end
        end else if (sel_stat) begin
            in_port_d = pack_status(ST_CNT_W'(fifo_count), flags_q,
                                    fifo_full, ~fifo_empty);
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= '0;
            irq_q     <= 1'b0;
            in_port_q <= 16'h0000;
        end else begin
            flags_q   <= flags_d;
            irq_q     <= irq_d;
            in_port_q <= in_port_d;
        end
    end

    assign in_port   = in_port_q;
    assign interrupt = irq_q;

endmodule

// File: tb/tb_uart_rx_inport.sv
// Bench for uart_rx_inport: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_uart_rx_inport;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        rx_ferr;
    logic        rx_perr;
    logic [15:0] port_id;
    logic        read_strobe;
    logic        interrupt_ack;
    logic [15:0] in_port;
    logic        interrupt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  m_q[$];
    logic        m_ovf, m_ferr, m_perr, m_irq;
    logic [15:0] m_in;

    uart_rx_inport dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_rdy        (rx_rdy),
        .rx_ferr       (rx_ferr),
        .rx_perr       (rx_perr),
        .port_id       (port_id),
        .read_strobe   (read_strobe),
        .interrupt_ack (interrupt_ack),
        .in_port       (in_port),
        .interrupt     (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the model, using the inputs as sampled at that edge
    task automatic model_step();
        int          n;
        logic [15:0] nxt;
        bit          pop, push_ok, clr;
        if (reset) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
            m_perr = 1'b0;
            m_irq  = 1'b0;
            m_in   = 16'h0000;
        end else begin
            n   = m_q.size();
            nxt = 16'h0000;
            if (port_id == 16'h0000) begin
                if (n > 0) nxt = {8'h00, m_q[0]};
            end else if (port_id == 16'h0001) begin
                nxt = {4'h0, 4'(n), 3'b000, m_perr, m_ferr, m_ovf, (n == 8), (n != 0)};
            end
            pop     = read_strobe && (port_id == 16'h0000) && (n > 0);
            push_ok = rx_rdy && ((n < 8) || pop);
            clr     = read_strobe && (port_id == 16'h0001);
            m_ovf   = (rx_rdy && !push_ok) || (m_ovf  && !clr);
            m_ferr  = (rx_rdy && rx_ferr)  || (m_ferr && !clr);
            m_perr  = (rx_rdy && rx_perr)  || (m_perr && !clr);
            if (pop)     void'(m_q.pop_front());
            if (push_ok) m_q.push_back(rx_data);
            if (push_ok)            m_irq = 1'b1;
            else if (interrupt_ack) m_irq = 1'b0;
            m_in = nxt;
        end
    endtask

    task automatic monitor();
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("cyc_in_port", in_port, m_in);
            check("cyc_interrupt", {15'h0, interrupt}, {15'h0, m_irq});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic fe, input logic pe);
        rx_data = b;
        rx_rdy  = 1'b1;
        rx_ferr = fe;
        rx_perr = pe;
        tick();
        rx_rdy  = 1'b0;
        rx_ferr = 1'b0;
        rx_perr = 1'b0;
    endtask

    // Present PORT_ID for a cycle, check IN_PORT, then strobe it
    task automatic rd_port(input logic [15:0] id, input logic [15:0] exp, input string name);
        port_id     = id;
        read_strobe = 1'b0;
        tick();
        check(name, in_port, exp);
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
    endtask

    // Look at a port without strobing it
    task automatic peek(input logic [15:0] id, input logic [15:0] exp, input string name);
        port_id     = id;
        read_strobe = 1'b0;
        tick();
        check(name, in_port, exp);
    endtask

    initial begin
        reset         = 1'b1;
        rx_data       = 8'h00;
        rx_rdy        = 1'b0;
        rx_ferr       = 1'b0;
        rx_perr       = 1'b0;
        port_id       = 16'h0000;
        read_strobe   = 1'b0;
        interrupt_ack = 1'b0;
        m_ovf = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_irq = 1'b0; m_in = 16'h0000;
        fork
            monitor();
        join_none

        // 1: reset state, three pushes, status
        tick();
        tick();
        check("rst_in_port", in_port, 16'h0000);
        check("rst_interrupt", {15'h0, interrupt}, 16'h0000);
        reset = 1'b0;
        tick();
        push(8'h41, 1'b0, 1'b0);
        check("irq_after_push", {15'h0, interrupt}, 16'h0001);
        push(8'h42, 1'b0, 1'b0);
        push(8'h43, 1'b0, 1'b0);
        rd_port(16'h0001, 16'h0301, "stat_3bytes");

        // 2: pop three, then read empty
        rd_port(16'h0000, 16'h0041, "pop_41");
        rd_port(16'h0000, 16'h0042, "pop_42");
        rd_port(16'h0000, 16'h0043, "pop_43");
        rd_port(16'h0000, 16'h0000, "pop_empty");
        peek(16'h0001, 16'h0000, "stat_empty");
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        check("irq_ack", {15'h0, interrupt}, 16'h0000);

        // 3: fill, overflow, sticky clear
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0);
        rd_port(16'h0001, 16'h0807, "stat_ovf");
        peek(16'h0001, 16'h0803, "stat_ovf_clr");
        peek(16'h0007, 16'h0000, "other_id");

        // 4: push+pop while full, order across wrap
        peek(16'h0000, 16'h0010, "head_full");
        rx_data     = 8'h18;
        rx_rdy      = 1'b1;
        read_strobe = 1'b1;
        tick();
        rx_rdy      = 1'b0;
        read_strobe = 1'b0;
        peek(16'h0001, 16'h0803, "stat_full_pp");
        for (int i = 0; i < 8; i++) rd_port(16'h0000, 16'h0011 + 16'(i), "pop_wrap");

        // 5: set beats clear, ack vs push
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        check("irq_ack2", {15'h0, interrupt}, 16'h0000);
        port_id       = 16'h0001;
        read_strobe   = 1'b1;
        rx_data       = 8'h55;
        rx_rdy        = 1'b1;
        rx_ferr       = 1'b1;
        interrupt_ack = 1'b1;
        tick();
        read_strobe   = 1'b0;
        rx_rdy        = 1'b0;
        rx_ferr       = 1'b0;
        interrupt_ack = 1'b0;
        check("irq_set_wins", {15'h0, interrupt}, 16'h0001);
        peek(16'h0001, 16'h0109, "stat_ferr_kept");
        push(8'h66, 1'b0, 1'b1);
        rd_port(16'h0001, 16'h0219, "stat_perr");
        peek(16'h0001, 16'h0201, "stat_errs_clr");

        // 6: reset with five bytes queued
        push(8'h01, 1'b0, 1'b0);
        push(8'h02, 1'b0, 1'b0);
        push(8'h03, 1'b0, 1'b0);
        peek(16'h0001, 16'h0501, "stat_5bytes");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_in_port", in_port, 16'h0000);
        check("midrst_interrupt", {15'h0, interrupt}, 16'h0000);
        peek(16'h0001, 16'h0000, "midrst_stat");
        peek(16'h0000, 16'h0000, "midrst_rx");

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
